modulo_controle_rolhas: RTL and testbench

MODULO_CONTROLE_ROLHAS -- requirements
Module: modulo_controle_rolhas

---
 rtl/rolhas_defs.sv | 22 ++
 rtl/contador_estoque_rolhas.sv | 43 ++++
 rtl/modulo_controle_rolhas.sv | 78 +++++++
 tb/tb_modulo_controle_rolhas.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rolhas_defs.sv
// ============================================================================
// Module      : rolhas_defs
// Description : Shared constants and state encoding for the cork controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rolhas_defs;

    localparam int W_ESTOQUE = 7;
    localparam int W_DISP    = 4;

    localparam logic [W_DISP-1:0]    CAP_DISP    = 4'd15;
    localparam logic [W_DISP-1:0]    LIMIAR      = 4'd3;
    localparam logic [W_ESTOQUE-1:0] MAX_ESTOQUE = 7'd99;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_TRANSFER = 1'b1;

endpackage

`default_nettype wire

// File: rtl/contador_estoque_rolhas.sv
// ============================================================================
// Module      : contador_estoque_rolhas
// Description : Saturating up/down counter for the cork stock (0..MAX_ESTOQUE).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_estoque_rolhas
    import rolhas_defs::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [W_ESTOQUE-1:0] count_o
);

    logic [W_ESTOQUE-1:0] count_q;
    logic [W_ESTOQUE-1:0] count_d;

    // Simultaneous inc and dec cancel before any saturation is applied.
    always_comb begin
        count_d = count_q;
        case ({inc_i, dec_i})
            2'b10: if (count_q != MAX_ESTOQUE) count_d = count_q + 7'd1;
            2'b01: if (count_q != '0)          count_d = count_q - 7'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/modulo_controle_rolhas.sv
// ============================================================================
// Module      : modulo_controle_rolhas
// Description : Cork stock/dispenser controller with IDLE/TRANSFER refill FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module modulo_controle_rolhas
    import rolhas_defs::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 add_rolha,
    input  logic                 consome_rolha,
    input  logic                 transfer_rolhas,
    output logic [W_ESTOQUE-1:0] reg_r,
    output logic [W_DISP-1:0]    dispensador,
    output logic                 transferindo,
    output logic                 vazio,
    output logic                 erro_consumo
);

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [W_DISP-1:0] disp_q;
    logic [W_DISP-1:0] disp_d;
    logic              erro_q;
    logic              erro_d;
    logic              in_transfer;
    logic              consume_ok;

    assign in_transfer = (state_q == ST_TRANSFER);
    assign consume_ok  = consome_rolha && (disp_q != '0);

    contador_estoque_rolhas u_estoque (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (add_rolha),
        .dec_i   (in_transfer),
        .count_o (reg_r)
    );

    // The exit test uses the post-consume count so a net-zero cycle keeps refilling.
    always_comb begin
        state_d = state_q;
        erro_d  = consome_rolha && (disp_q == '0);
        disp_d  = disp_q + {3'b000, in_transfer} - {3'b000, consume_ok};
        case (state_q)
            ST_IDLE: begin
                if (transfer_rolhas && (disp_q < LIMIAR)) state_d = ST_TRANSFER;
            end
            ST_TRANSFER: begin
                if (disp_d == CAP_DISP) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            disp_q  <= '0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            erro_q  <= erro_d;
        end
    end

    assign dispensador  = disp_q;
    assign transferindo = in_transfer;
    assign erro_consumo = erro_q;
    assign vazio        = (disp_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_modulo_controle_rolhas.sv
// ============================================================================
// Module      : tb_modulo_controle_rolhas
// Description : Self-checking bench: directed scenarios plus random pulses vs. a cork-count model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modulo_controle_rolhas;

    logic       clk;
    logic       reset;
    logic       add_rolha;
    logic       consome_rolha;
    logic       transfer_rolhas;
    logic [6:0] reg_r;
    logic [3:0] dispensador;
    logic       transferindo;
    logic       vazio;
    logic       erro_consumo;

    int n_checks;
    int n_fail;

    // Reference state: corks in stock, corks in dispenser, refill active, error pulse.
    int m_stock;
    int m_disp;
    bit m_trans;
    bit m_err;

    // Stand-in for the external comparator stage.
    assign transfer_rolhas = (reg_r >= 7'd20);

    modulo_controle_rolhas dut (
        .clk             (clk),
        .reset           (reset),
        .add_rolha       (add_rolha),
        .consome_rolha   (consome_rolha),
        .transfer_rolhas (transfer_rolhas),
        .reg_r           (reg_r),
        .dispensador     (dispensador),
        .transferindo    (transferindo),
        .vazio           (vazio),
        .erro_consumo    (erro_consumo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input bit add, input bit cons, input bit rst);
        int  new_stock;
        int  new_disp;
        bit  new_trans;
        if (rst) begin
            m_stock = 0;
            m_disp  = 0;
            m_trans = 1'b0;
            m_err   = 1'b0;
            return;
        end
        new_stock = m_stock + (add ? 1 : 0) - (m_trans ? 1 : 0);
        if (new_stock > 99) new_stock = 99;
        if (new_stock < 0)  new_stock = 0;
        new_disp = m_disp + (m_trans ? 1 : 0) - ((cons && m_disp > 0) ? 1 : 0);
        if (m_trans) new_trans = (new_disp != 15);
        else         new_trans = (m_stock >= 20) && (m_disp < 3);
        m_err   = cons && (m_disp == 0);
        m_stock = new_stock;
        m_disp  = new_disp;
        m_trans = new_trans;
    endtask

    task automatic step(input bit add, input bit cons, input bit rst);
        @(negedge clk);
        add_rolha     = add;
        consome_rolha = cons;
        reset         = rst;
        model_update(add, cons, rst);
        @(posedge clk);
        #1;
        chk("reg_r",        int'(reg_r),        m_stock);
        chk("dispensador",  int'(dispensador),  m_disp);
        chk("transferindo", int'(transferindo), int'(m_trans));
        chk("vazio",        int'(vazio),        (m_disp == 0) ? 1 : 0);
        chk("erro_consumo", int'(erro_consumo), int'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic adds(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic run_until_disp(input int target);
        int guard;
        guard = 0;
        while (!(m_trans && m_disp == target) && guard < 40) begin
            step(1'b0, 1'b0, 1'b0);
            guard++;
        end
        chk("wait_disp_reached", (guard < 40) ? 1 : 0, 1);
    endtask

    initial begin
        int saved_stock;
        int saved_disp;
        int p_add;
        int p_cons;
        bit r_add;
        bit r_cons;
        bit r_rst;

        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        add_rolha     = 1'b0;
        consome_rolha = 1'b0;
        m_stock = 0; m_disp = 0; m_trans = 1'b0; m_err = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("reset_vazio", int'(vazio), 1);

        // 25 loads, then a full refill to 15
        adds(25);
        idle(20);
        chk("fill_reg_r",  int'(reg_r),        10);
        chk("fill_disp",   int'(dispensador),  15);
        chk("fill_trans",  int'(transferindo), 0);

        // Stock saturates at 99 without error
        adds(95);
        chk("sat_reg_r", int'(reg_r), 99);
        step(1'b1, 1'b0, 1'b0);
        chk("sat_hold",  int'(reg_r), 99);
        chk("sat_noerr", int'(erro_consumo), 0);

        // Consume from an empty dispenser
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("empty_err",  int'(erro_consumo), 1);
        chk("empty_disp", int'(dispensador),  0);
        idle(1);
        chk("empty_err_drop", int'(erro_consumo), 0);

        // Simultaneous add and consume mid-transfer at 5
        step(1'b0, 1'b0, 1'b1);
        adds(20);
        run_until_disp(5);
        saved_stock = m_stock;
        saved_disp  = m_disp;
        step(1'b1, 1'b1, 1'b0);
        chk("net_reg_r", int'(reg_r),       saved_stock);
        chk("net_disp",  int'(dispensador), saved_disp);
        idle(20);
        chk("net_done_disp",  int'(dispensador),  15);
        chk("net_done_trans", int'(transferindo), 0);

        // Threshold boundary 19 -> 20
        step(1'b0, 1'b0, 1'b1);
        adds(19);
        idle(3);
        chk("thr19_trans", int'(transferindo), 0);
        adds(1);
        chk("thr20_reg_r", int'(reg_r),        20);
        chk("thr20_trans", int'(transferindo), 0);
        idle(1);
        chk("thr20_start", int'(transferindo), 1);

        // Reset aborts a refill at 7
        run_until_disp(7);
        step(1'b0, 1'b0, 1'b1);
        chk("abort_reg_r", int'(reg_r),        0);
        chk("abort_disp",  int'(dispensador),  0);
        chk("abort_trans", int'(transferindo), 0);
        chk("abort_vazio", int'(vazio),        1);
        idle(2);
        chk("abort_stay_idle", int'(transferindo), 0);

        // Random pulse traffic with sporadic resets
        p_add  = 50;
        p_cons = 30;
        for (int i = 0; i < 4000; i++) begin
            if (i % 256 == 0) begin
                p_add  = $urandom_range(5, 95);
                p_cons = $urandom_range(0, 90);
            end
            r_add  = ($urandom_range(0, 99) < p_add);
            r_cons = ($urandom_range(0, 99) < p_cons);
            r_rst  = ($urandom_range(0, 299) == 0);
            step(r_add, r_cons, r_rst);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
